izh_spike_monitor: RTL and testbench



---
 rtl/izh_spike_monitor.sv | 148 ++++++++++++++
 tb/tb_izh_spike_monitor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/izh_spike_monitor.sv
// Spike detector and inter-spike-interval monitor for the Izhikevich neuron core.
// Upward threshold crossings on update steps yield a spike pulse; the ISIs go into a small FWFT FIFO.
module izh_spike_monitor #(
  parameter logic signed [7:0] THRESH = 8'sd19,
  parameter int unsigned       ISI_W  = 16,
  parameter int unsigned       DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    step,
  input  logic signed [7:0]       v_in,
  input  logic                    clear,
  output logic                    spike,
  output logic [ISI_W-1:0]        isi_data,
  output logic                    isi_valid,
  input  logic                    isi_ready,
  output logic                    overflow,
  output logic [15:0]             spike_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  logic             armed_q, armed_d;
  logic             have_ref_q, have_ref_d;
  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             spike_q, spike_d;
  logic [15:0]      spike_count_q, spike_count_d;
  logic             overflow_q, overflow_d;
  logic [ISI_W-1:0] mem_q [DEPTH];

  logic             above;
  logic             detect;
  logic             full;
  logic             pop;
  logic             push;
  logic             push_ok;
  logic [ISI_W-1:0] isi_sat;

  assign above   = v_in > THRESH;
  assign detect  = step & above & armed_q;
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = (count_q != '0) & isi_ready;
  assign push    = detect & have_ref_q;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok = push & (~full | pop) & ~clear;
  assign isi_sat = (isi_cnt_q == ISI_MAX) ? ISI_MAX : isi_cnt_q + 1'b1;

  always_comb begin
    armed_d       = armed_q;
    have_ref_d    = have_ref_q;
    isi_cnt_d     = isi_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    spike_d       = 1'b0;
    spike_count_d = spike_count_q;
    overflow_d    = overflow_q;

    if (clear) begin
      armed_d       = 1'b0;
      have_ref_d    = 1'b0;
      isi_cnt_d     = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
      spike_count_d = '0;
      overflow_d    = 1'b0;
    end else begin
      if (step) begin
        if (!above) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
        end

        if (detect) begin
          spike_d    = 1'b1;
          isi_cnt_d  = '0;
          have_ref_d = 1'b1;
          if (spike_count_q != 16'hFFFF) begin
            spike_count_d = spike_count_q + 16'd1;
          end
        end else begin
          isi_cnt_d = isi_sat;
        end
      end

      if (push && full && !pop) begin
        overflow_d = 1'b1;
      end
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push_ok, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q       <= 1'b0;
      have_ref_q    <= 1'b0;
      isi_cnt_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      spike_q       <= 1'b0;
      spike_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      armed_q       <= armed_d;
      have_ref_q    <= have_ref_d;
      isi_cnt_q     <= isi_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      spike_q       <= spike_d;
      spike_count_q <= spike_count_d;
      overflow_q    <= overflow_d;
    end
  end

  // Storage carries no reset; stale words are never visible because data is gated by valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= isi_sat;
    end
  end

  assign spike       = spike_q;
  assign isi_valid   = (count_q != '0);
  assign isi_data    = isi_valid ? mem_q[rd_ptr_q] : '0;
  assign overflow    = overflow_q;
  assign spike_count = spike_count_q;

endmodule

// File: tb/tb_izh_spike_monitor.sv
// Directed bench for izh_spike_monitor: vector table for detection/ISI basics,
// hand sequences for FIFO overflow, push-while-full, saturation, clear and async reset.
module tb_izh_spike_monitor;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              step;
  logic signed [7:0] v_in;
  logic              clear;
  logic              isi_ready;

  logic        spike_a, isi_valid_a, overflow_a;
  logic [15:0] isi_data_a, spike_count_a;
  logic        spike_b, isi_valid_b, overflow_b;
  logic [3:0]  isi_data_b;
  logic [15:0] spike_count_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  izh_spike_monitor #(.THRESH(8'sd19), .ISI_W(16), .DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .step(step), .v_in(v_in), .clear(clear),
    .spike(spike_a), .isi_data(isi_data_a), .isi_valid(isi_valid_a),
    .isi_ready(isi_ready), .overflow(overflow_a), .spike_count(spike_count_a)
  );

  // Narrow-ISI instance shares all stimulus; only examined for saturation.
  izh_spike_monitor #(.THRESH(8'sd19), .ISI_W(4), .DEPTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .step(step), .v_in(v_in), .clear(clear),
    .spike(spike_b), .isi_data(isi_data_b), .isi_valid(isi_valid_b),
    .isi_ready(isi_ready), .overflow(overflow_b), .spike_count(spike_count_b)
  );

  typedef struct {
    logic              st;
    logic signed [7:0] v;
    logic              clr;
    logic              rdy;
    logic              e_spike;
    logic              e_valid;
    logic [15:0]       e_data;
    logic [15:0]       e_count;
    logic              e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic e_spike, input logic e_valid,
                         input logic [15:0] e_data, input logic [15:0] e_count, input logic e_ovf);
    chk($sformatf("%s spike", tag),       32'(spike_a),       32'(e_spike));
    chk($sformatf("%s isi_valid", tag),   32'(isi_valid_a),   32'(e_valid));
    chk($sformatf("%s isi_data", tag),    32'(isi_data_a),    32'(e_data));
    chk($sformatf("%s spike_count", tag), 32'(spike_count_a), 32'(e_count));
    chk($sformatf("%s overflow", tag),    32'(overflow_a),    32'(e_ovf));
  endtask

  task automatic cyc(input logic st, input logic signed [7:0] v, input logic clr, input logic rdy);
    step      = st;
    v_in      = v;
    clear     = clr;
    isi_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // k-1 sub-threshold steps then one crossing step: ISI of k when a reference exists.
  task automatic spike_after(input int k, input logic rdy_on_spike);
    for (int i = 0; i < k - 1; i++) cyc(1'b1, 8'sd0, 1'b0, 1'b0);
    cyc(1'b1, 8'sd50, 1'b0, rdy_on_spike);
  endtask

  task automatic addv(input logic st, input logic signed [7:0] v, input logic clr, input logic rdy,
                      input logic es, input logic ev, input logic [15:0] ed,
                      input logic [15:0] ec, input logic eo);
    vec_t t;
    t.st = st; t.v = v; t.clr = clr; t.rdy = rdy;
    t.e_spike = es; t.e_valid = ev; t.e_data = ed; t.e_count = ec; t.e_ovf = eo;
    vecs.push_back(t);
  endtask

  initial begin
    rst_n     = 1'b0;
    step      = 1'b1;
    v_in      = -8'sd45;
    clear     = 1'b0;
    isi_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_a("reset", 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    chk("reset b isi_valid", 32'(isi_valid_b), 32'd0);
    step  = 1'b0;
    rst_n = 1'b1;

    // Idle below threshold, then spikes on steps 5 and 12 (one step=0 gap inside).
    for (int i = 0; i < 10; i++) addv(1, -8'sd23, 0, 0, 0, 0, 16'd0, 16'd0, 0);
    for (int i = 0; i < 4; i++)  addv(1,  8'sd19, 0, 0, 0, 0, 16'd0, 16'd0, 0);
    addv(1, 8'sd20, 0, 0, 1, 0, 16'd0, 16'd1, 0);
    for (int i = 0; i < 3; i++)  addv(1, -8'sd23, 0, 0, 0, 0, 16'd0, 16'd1, 0);
    addv(0, 8'sd100, 0, 0, 0, 0, 16'd0, 16'd1, 0);
    for (int i = 0; i < 3; i++)  addv(1, -8'sd23, 0, 0, 0, 0, 16'd0, 16'd1, 0);
    addv(1, 8'sd40, 0, 0, 1, 1, 16'd7, 16'd2, 0);
    addv(0, 8'sd0,  0, 0, 0, 1, 16'd7, 16'd2, 0);
    addv(0, 8'sd0,  0, 1, 0, 0, 16'd0, 16'd2, 0);
    // Arming: start above threshold after clear, no spike until it dips.
    addv(1, 8'sd50, 1, 0, 0, 0, 16'd0, 16'd0, 0);
    for (int i = 0; i < 6; i++)  addv(1, 8'sd50, 0, 0, 0, 0, 16'd0, 16'd0, 0);
    addv(1, 8'sd0,  0, 0, 0, 0, 16'd0, 16'd0, 0);
    addv(1, 8'sd50, 0, 0, 1, 0, 16'd0, 16'd1, 0);
    addv(1, 8'sd50, 0, 0, 0, 0, 16'd0, 16'd1, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].st, vecs[i].v, vecs[i].clr, vecs[i].rdy);
      check_a($sformatf("vec%0d", i), vecs[i].e_spike, vecs[i].e_valid,
              vecs[i].e_data, vecs[i].e_count, vecs[i].e_ovf);
    end

    // FIFO full and overflow: 6 spikes 3 steps apart, no consumer.
    cyc(1'b1, 8'sd0, 1'b1, 1'b0);
    cyc(1'b1, 8'sd0, 1'b0, 1'b0);
    for (int s = 0; s < 5; s++) spike_after(3, 1'b0);
    check_a("ovf 4 pushes", 1'b1, 1'b1, 16'd3, 16'd5, 1'b0);
    spike_after(3, 1'b0);
    check_a("ovf 5th push", 1'b1, 1'b1, 16'd3, 16'd6, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf pop%0d valid", i), 32'(isi_valid_a), 32'd1);
      chk($sformatf("ovf pop%0d data", i),  32'(isi_data_a),  32'd3);
      cyc(1'b0, 8'sd0, 1'b0, 1'b1);
    end
    check_a("ovf drained", 1'b0, 1'b0, 16'd0, 16'd6, 1'b1);

    // Push and pop on the same edge while full: no drop, order kept.
    cyc(1'b1, 8'sd0, 1'b1, 1'b0);
    check_a("clear2", 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    cyc(1'b1, 8'sd0, 1'b0, 1'b0);
    spike_after(2, 1'b0);
    for (int k = 2; k <= 5; k++) spike_after(k, 1'b0);
    check_a("full", 1'b1, 1'b1, 16'd2, 16'd5, 1'b0);
    spike_after(6, 1'b1);
    check_a("push+pop full", 1'b1, 1'b1, 16'd3, 16'd6, 1'b0);
    for (int k = 3; k <= 6; k++) begin
      chk($sformatf("order%0d valid", k), 32'(isi_valid_a), 32'd1);
      chk($sformatf("order%0d data", k),  32'(isi_data_a),  32'(k));
      cyc(1'b0, 8'sd0, 1'b0, 1'b1);
    end
    chk("order empty", 32'(isi_valid_a), 32'd0);
    chk("order ovf",   32'(overflow_a),  32'd0);

    // ISI saturation on the 4-bit instance, then clear on a crossing step.
    cyc(1'b1, 8'sd0, 1'b1, 1'b0);
    cyc(1'b1, 8'sd0, 1'b0, 1'b0);
    cyc(1'b1, 8'sd50, 1'b0, 1'b0);
    spike_after(20, 1'b0);
    chk("sat a data",  32'(isi_data_a),  32'd20);
    chk("sat b valid", 32'(isi_valid_b), 32'd1);
    chk("sat b data",  32'(isi_data_b),  32'd15);
    chk("sat b count", 32'(spike_count_b), 32'd2);
    cyc(1'b1, 8'sd0, 1'b0, 1'b0);
    cyc(1'b1, 8'sd50, 1'b1, 1'b0);
    check_a("clear on crossing", 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    chk("clear b spike", 32'(spike_b),     32'd0);
    chk("clear b valid", 32'(isi_valid_b), 32'd0);
    chk("clear b count", 32'(spike_count_b), 32'd0);

    // Asynchronous reset mid-cycle discards the FIFO without a clock edge.
    cyc(1'b1, 8'sd0, 1'b0, 1'b0);
    cyc(1'b1, 8'sd50, 1'b0, 1'b0);
    spike_after(2, 1'b0);
    check_a("pre async", 1'b1, 1'b1, 16'd2, 16'd2, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_a("async reset", 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
